// File: rtl/div32_seq_if.sv
// Handshake and result bus between the control unit and the sequential divider.
// The control unit is the master; the divider is the slave.
interface div32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32_seq.sv
// Multi-cycle signed/unsigned restoring divider: strip signs, run WIDTH
// shift/subtract iterations on magnitudes, then re-apply signs to the results.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  div32_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] dvd_reg, dvs_reg, rem_reg, quo_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             sop_reg, sign_q_reg, sign_r_reg;
  logic             busy_reg, done_reg, dbz_reg;
  logic [WIDTH:0]   trial, diff;
  logic             div_zero;

  // One extra bit on the trial subtract so its MSB acts as the borrow.
  always_comb begin
    trial    = {rem_reg, quo_reg[WIDTH-1]};
    diff     = trial - {1'b0, dvs_reg};
    div_zero = (dvs_reg == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = PREP;
      PREP: state_next = div_zero ? IDLE : ITER;
      ITER: if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      sop_reg       <= 1'b0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            dvd_reg  <= bus.dividend;
            dvs_reg  <= bus.divisor;
            sop_reg  <= bus.signed_op;
            busy_reg <= 1'b1;
          end
        end
        PREP: begin
          sign_q_reg <= sop_reg & (dvd_reg[WIDTH-1] ^ dvs_reg[WIDTH-1]);
          sign_r_reg <= sop_reg & dvd_reg[WIDTH-1];
          // abs(-2^(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude.
          quo_reg    <= (sop_reg && dvd_reg[WIDTH-1]) ? -dvd_reg : dvd_reg;
          dvs_reg    <= (sop_reg && dvs_reg[WIDTH-1]) ? -dvs_reg : dvs_reg;
          rem_reg    <= '0;
          cnt_reg    <= CW'(WIDTH);
          if (div_zero) begin
            quotient_reg  <= '1;
            remainder_reg <= dvd_reg;
            dbz_reg       <= 1'b1;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        ITER: begin
          if (!diff[WIDTH]) begin
            rem_reg <= diff[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= trial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - CW'(1);
        end
        FIX: begin
          quotient_reg  <= sign_q_reg ? -quo_reg : quo_reg;
          remainder_reg <= sign_r_reg ? -rem_reg : rem_reg;
          dbz_reg       <= 1'b0;
          done_reg      <= 1'b1;
          busy_reg      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule
